// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues credit-limited in-order reads,
// tags and buffers responses for decode, and squashes in-flight work on redirect.
module fetch_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_im_req_valid,
  input  logic            i_im_req_ready,
  output logic [XLEN-1:0] o_im_addr,
  input  logic            i_im_rdata_valid,
  input  logic [XLEN-1:0] i_im_rdata,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_id_instr,
  output logic [XLEN-1:0] o_id_pc,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_halt,
  output logic            o_misaligned
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_HALT, S_FAULT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req_valid;
  logic            r_misaligned;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_discard;
  logic [XLEN-1:0] r_pcq [DEPTH];
  logic [PW-1:0]   r_pcq_wr;
  logic [PW-1:0]   r_pcq_rd;
  logic [XLEN-1:0] r_fifo_instr [DEPTH];
  logic [XLEN-1:0] r_fifo_pc [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic            w_mis;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [CW-1:0]   w_out_next;
  logic [CW-1:0]   w_count_next;
  logic [SW-1:0]   w_sum_next;
  state_t          w_state_next;
  logic            w_req_next;

  always_comb begin
    w_accept     = r_req_valid & i_im_req_ready;
    w_mis        = i_redirect & (i_redirect_pc[1:0] != 2'b00);
    w_pop        = (r_count != '0) & i_id_ready;
    w_drop       = i_im_rdata_valid & (r_discard != '0);
    w_push       = i_im_rdata_valid & (r_discard == '0);
    w_out_next   = r_out + CW'(w_accept) - CW'(i_im_rdata_valid);
    w_count_next = i_redirect ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    w_sum_next   = SW'(w_out_next) + SW'(w_count_next);
  end

  always_comb begin
    w_state_next = r_state;
    if (w_mis) begin
      w_state_next = S_FAULT;
    end else begin
      case (r_state)
        S_RESET: w_state_next = S_FETCH;
        S_FETCH: if (i_halt) w_state_next = S_HALT;
        S_HALT:  if (!i_halt) w_state_next = S_FETCH;
        default: w_state_next = S_FAULT;
      endcase
    end
  end

  // Request valid is registered from next-cycle credits; a pending request
  // survives entry into HALT and is only withdrawn by a redirect.
  always_comb begin
    w_req_next = 1'b0;
    if (w_mis) begin
      w_req_next = 1'b0;
    end else if (r_req_valid && !i_im_req_ready && !i_redirect) begin
      w_req_next = 1'b1;
    end else begin
      w_req_next = (w_state_next == S_FETCH) && (w_sum_next < SW'(DEPTH));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_RESET;
      r_pc         <= RESET_PC;
      r_req_valid  <= 1'b0;
      r_misaligned <= 1'b0;
      r_out        <= '0;
      r_discard    <= '0;
      r_pcq_wr     <= '0;
      r_pcq_rd     <= '0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_count      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pcq[i]        <= '0;
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
    end else begin
      r_state      <= w_state_next;
      r_req_valid  <= w_req_next;
      r_misaligned <= w_mis;
      r_out        <= w_out_next;
      r_count      <= w_count_next;

      if (w_accept) begin
        r_pcq[r_pcq_wr] <= r_pc;
        r_pcq_wr        <= r_pcq_wr + 1'b1;
      end
      if (i_im_rdata_valid) begin
        r_pcq_rd <= r_pcq_rd + 1'b1;
      end

      if (i_redirect) begin
        r_discard <= w_out_next;
      end else if (w_drop) begin
        r_discard <= r_discard - 1'b1;
      end

      if (i_redirect && !w_mis) begin
        r_pc <= i_redirect_pc;
      end else if (w_accept) begin
        r_pc <= r_pc + XLEN'(4);
      end

      if (i_redirect) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) begin
          r_fifo_instr[r_wr] <= i_im_rdata;
          r_fifo_pc[r_wr]    <= r_pcq[r_pcq_rd];
          r_wr               <= r_wr + 1'b1;
        end
        if (w_pop) begin
          r_rd <= r_rd + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(w_push && !w_pop && (r_count == CW'(DEPTH))));
    end
  end

  assign o_im_req_valid = r_req_valid;
  assign o_im_addr      = r_pc;
  assign o_id_valid     = (r_count != '0);
  assign o_id_instr     = r_fifo_instr[r_rd];
  assign o_id_pc        = r_fifo_pc[r_rd];
  assign o_misaligned   = r_misaligned;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, checked
// every cycle against a queue-based model of fetch, memory and decode buffering.
module tb_fetch_sequencer;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_im_req_valid;
  logic        i_im_req_ready;
  logic [31:0] o_im_addr;
  logic        i_im_rdata_valid;
  logic [31:0] i_im_rdata;
  logic        o_id_valid;
  logic        i_id_ready;
  logic [31:0] o_id_instr;
  logic [31:0] o_id_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_halt;
  logic        o_misaligned;

  fetch_sequencer #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_im_req_valid(o_im_req_valid), .i_im_req_ready(i_im_req_ready), .o_im_addr(o_im_addr),
    .i_im_rdata_valid(i_im_rdata_valid), .i_im_rdata(i_im_rdata),
    .o_id_valid(o_id_valid), .i_id_ready(i_id_ready), .o_id_instr(o_id_instr), .o_id_pc(o_id_pc),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .i_halt(i_halt),
    .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } fe_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_due = -1;
  int first_acc = -1;
  int first_idv = -1;

  // Reference model: fetch PC, credits, discard count, tag queue, decode buffer.
  logic [31:0] m_pc;
  int          m_out, m_disc;
  bit          m_reqv, m_mis, m_boot, m_halted, m_fault;
  fe_t         fifo[$];
  logic [31:0] pcq[$];
  mreq_t       memq[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1111_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rdy, input logic idr, input logic hlt, input logic rd,
                            input logic [31:0] rpc, input int lat, input logic rv,
                            input logic [31:0] rdata);
    bit acc, mis, redir, pop, hold;
    int due;
    logic [31:0] a;
    acc   = m_reqv && rdy;
    mis   = rd && (rpc[1:0] != 2'b00);
    redir = rd && !mis;
    pop   = (fifo.size() != 0) && idr;
    if (acc) begin
      pcq.push_back(m_pc);
      m_out++;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      memq.push_back('{m_pc, due});
      last_due = due;
    end
    if (pop) fifo.delete(0);
    if (rv) begin
      m_out--;
      a = pcq.pop_front();
      if (m_disc > 0) m_disc--;
      else fifo.push_back('{rdata, a});
    end
    if (rd) begin
      fifo.delete();
      m_disc = m_out;
    end
    hold = m_reqv && !acc && !rd;
    if (redir) m_pc = rpc;
    else if (acc) m_pc = m_pc + 32'd4;
    m_mis = mis;
    if (mis) m_fault = 1;
    else if (!m_fault) begin
      if (m_boot) m_boot = 0;
      else if (!m_halted && hlt) m_halted = 1;
      else if (m_halted && !hlt) m_halted = 0;
    end
    m_reqv = hold || (!m_fault && !m_boot && !m_halted && (m_out + fifo.size() < DEPTH));
  endtask

  task automatic cycle(input logic rdy, input logic idr, input logic hlt, input logic rd,
                       input logic [31:0] rpc, input int lat);
    logic        rv;
    logic [31:0] rdata;
    rv = 1'b0;
    rdata = $urandom;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      rv = 1'b1;
      rdata = word_of(memq[0].addr);
      memq.delete(0);
    end
    i_im_req_ready = rdy; i_id_ready = idr; i_halt = hlt;
    i_redirect = rd; i_redirect_pc = rpc;
    i_im_rdata_valid = rv; i_im_rdata = rdata;
    #1;
    chk("req_valid", 32'(o_im_req_valid), 32'(m_reqv));
    chk("im_addr", o_im_addr, m_pc);
    chk("id_valid", 32'(o_id_valid), 32'(fifo.size() != 0));
    if (fifo.size() != 0) begin
      chk("id_instr", o_id_instr, fifo[0].instr);
      chk("id_pc", o_id_pc, fifo[0].pc);
    end
    chk("misaligned", 32'(o_misaligned), 32'(m_mis));
    if (o_id_valid && first_idv < 0) first_idv = cyc;
    if (m_reqv && rdy && first_acc < 0) first_acc = cyc;
    model_step(rdy, idr, hlt, rd, rpc, lat, rv, rdata);
    @(negedge i_clk);
    cyc++;
  endtask

  // Reset is asserted mid-cycle so its asynchronous effect is observed at once.
  task automatic reset_dut(input int n);
    #2;
    i_rst = 1'b1;
    i_im_req_ready = 0; i_id_ready = 0; i_halt = 0; i_redirect = 0;
    i_redirect_pc = '0; i_im_rdata_valid = 0; i_im_rdata = '0;
    #1;
    chk("rst_req_valid", 32'(o_im_req_valid), 32'd0);
    chk("rst_im_addr", o_im_addr, RST_PC);
    chk("rst_id_valid", 32'(o_id_valid), 32'd0);
    chk("rst_id_instr", o_id_instr, 32'd0);
    chk("rst_id_pc", o_id_pc, 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    m_pc = RST_PC; m_out = 0; m_disc = 0;
    m_reqv = 0; m_mis = 0; m_boot = 1; m_halted = 0; m_fault = 0;
    fifo.delete(); pcq.delete(); memq.delete();
    last_due = -1;
    repeat (n) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    bit reached;
    bit hlt;
    int fault_age;
    i_rst = 1'b1;
    i_im_req_ready = 0; i_id_ready = 0; i_halt = 0; i_redirect = 0;
    i_redirect_pc = '0; i_im_rdata_valid = 0; i_im_rdata = '0;
    @(negedge i_clk);

    // 1: streaming with single-cycle memory
    reset_dut(3);
    for (int i = 0; i < 14; i++) cycle(1, 1, 0, 0, '0, 1);
    chk("first_fetch_latency", 32'(first_idv - first_acc), 32'd2);

    // 2: decode stall fills credits, then drains in order
    reset_dut(2);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, '0, 1);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, '0, 1);

    // 3: redirect with two requests in flight
    reset_dut(2);
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      if (m_out == 2 && m_pc >= 32'h10) reached = 1;
      else cycle(1, 1, 0, 0, '0, 3);
    end
    chk("t3_setup", 32'(reached), 32'd1);
    cycle(1, 1, 0, 1, 32'h100, 3);
    for (int i = 0; i < 14; i++) cycle(1, 1, 0, 0, '0, 1);

    // 4: misaligned redirect faults until reset
    cycle(1, 1, 0, 1, 32'h102, 1);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, '0, 1);
    reset_dut(1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, '0, 1);

    // 5: halt while a request at 0x10 is pending
    reset_dut(1);
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (m_pc == 32'h10 && m_reqv) reached = 1;
      else cycle(m_pc != 32'h10, 1, 0, 0, '0, 1);
    end
    chk("t5_setup", 32'(reached), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, '0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, '0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, '0, 1);

    // 6: address wrap, then reset with requests outstanding
    cycle(1, 1, 0, 1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, '0, 1);
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      if (m_out == 2) reached = 1;
      else cycle(1, 1, 0, 0, '0, 3);
    end
    chk("t6_setup", 32'(reached), 32'd1);
    reset_dut(2);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, '0, 1);

    // Random traffic
    hlt = 0;
    fault_age = 0;
    for (int i = 0; i < 700; i++) begin
      logic [31:0] tgt;
      bit rd;
      if ($urandom_range(0, 19) == 0) hlt = ~hlt;
      rd  = ($urandom_range(0, 24) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      fault_age = m_fault ? fault_age + 1 : 0;
      if (fault_age > 8 || $urandom_range(0, 199) == 0) begin
        reset_dut($urandom_range(1, 3));
        fault_age = 0;
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, hlt, rd, tgt,
            $urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
